// File: rtl/serv_pwr_pkg.sv
// Shared types for the SERV WFI power controller: FSM state encoding and
// wake-timer sizing helper.
package serv_pwr_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SLEEP = 2'd2,
        WAKE  = 2'd3
    } state_t;

    // Bits needed to hold 0..dly, never less than one.
    function automatic int wake_tmr_w(input int dly);
        return (dly < 1) ? 1 : $clog2(dly + 1);
    endfunction

endpackage

// File: rtl/serv_pwr_wake_timer.sv
// Loadable down-counter that times the settle period spent in WAKE.
// done flags the last settle cycle (timer value 1).
module serv_pwr_wake_timer
    import serv_pwr_pkg::*;
#(
    parameter int WAKE_DLY = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int TW = wake_tmr_w(WAKE_DLY);

    logic [TW-1:0] timer_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            timer_reg <= '0;
        end else if (load) begin
            timer_reg <= TW'(WAKE_DLY);
        end else if (en && timer_reg != '0) begin
            timer_reg <= timer_reg - TW'(1);
        end
    end

    assign done = (timer_reg == TW'(1));

endmodule

// File: rtl/serv_pwr_ctrl.sv
// WFI sleep/wakeup responder: drains the bus, gates the core clock, and
// restores it after a settle delay. Define SERV_PWR_SLEEP_CNT_EN for the
// saturating gated-cycle counter; otherwise o_sleep_cycles reads zero.
module serv_pwr_ctrl
    import serv_pwr_pkg::*;
#(
    parameter int WAKE_DLY = 2,
    parameter int CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sleep_req,
    input  logic             i_wakeup_req,
    input  logic             i_bus_idle,
    output logic             o_clk_en,
    output logic             o_sleeping,
    output logic             o_wake_ack,
    output logic [CNT_W-1:0] o_sleep_cycles
);

    state_t state_reg;
    state_t state_next;
    logic   clk_en_reg;
    logic   sleeping_reg;
    logic   wake_ack_reg;
    logic   ack_next;
    logic   tmr_done;

    serv_pwr_wake_timer #(
        .WAKE_DLY (WAKE_DLY)
    ) u_wake_timer (
        .clk  (i_clk),
        .srst (i_rst),
        .load ((state_reg == SLEEP) && i_wakeup_req),
        .en   (state_reg == WAKE),
        .done (tmr_done)
    );

    always_comb begin
        state_next = state_reg;
        ack_next   = 1'b0;
        case (state_reg)
            RUN: begin
                // The core still holds sleep_req during the ack cycle.
                if (i_sleep_req && !wake_ack_reg) begin
                    if (i_wakeup_req) begin
                        ack_next = 1'b1;
                    end else begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (i_wakeup_req) begin
                    state_next = RUN;
                    ack_next   = 1'b1;
                end else if (i_bus_idle) begin
                    state_next = SLEEP;
                end
            end
            SLEEP: begin
                if (i_wakeup_req) begin
                    if (WAKE_DLY == 0) begin
                        state_next = RUN;
                        ack_next   = 1'b1;
                    end else begin
                        state_next = WAKE;
                    end
                end
            end
            WAKE: begin
                if (tmr_done) begin
                    state_next = RUN;
                    ack_next   = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= RUN;
            clk_en_reg   <= 1'b1;
            sleeping_reg <= 1'b0;
            wake_ack_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            clk_en_reg   <= (state_next == RUN) || (state_next == DRAIN);
            sleeping_reg <= (state_next == SLEEP) || (state_next == WAKE);
            wake_ack_reg <= ack_next;
        end
    end

    assign o_clk_en   = clk_en_reg;
    assign o_sleeping = sleeping_reg;
    assign o_wake_ack = wake_ack_reg;

`ifdef SERV_PWR_SLEEP_CNT_EN
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_reg <= '0;
        end else if (sleeping_reg && cnt_reg != '1) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign o_sleep_cycles = cnt_reg;
`else
    assign o_sleep_cycles = '0;
`endif

endmodule

// File: tb/tb_serv_pwr_ctrl.sv
// Directed bench for serv_pwr_ctrl: three instances (WAKE_DLY 2, 0, 4) share
// stimulus; each phase resets and checks the instance it targets.
module tb_serv_pwr_ctrl;

    logic clk = 1'b0;
    logic rst, sleep_req, wakeup_req, bus_idle;

    logic       clk_en2, sleeping2, ack2;
    logic [3:0] cyc2;
    logic       clk_en0, sleeping0, ack0;
    logic [3:0] cyc0;
    logic       clk_en4, sleeping4, ack4;
    logic [3:0] cyc4;

    int checks = 0;
    int errors = 0;

`ifdef SERV_PWR_SLEEP_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    serv_pwr_ctrl #(.WAKE_DLY(2), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_sleep_req(sleep_req),
        .i_wakeup_req(wakeup_req), .i_bus_idle(bus_idle),
        .o_clk_en(clk_en2), .o_sleeping(sleeping2), .o_wake_ack(ack2),
        .o_sleep_cycles(cyc2)
    );

    serv_pwr_ctrl #(.WAKE_DLY(0), .CNT_W(4)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_sleep_req(sleep_req),
        .i_wakeup_req(wakeup_req), .i_bus_idle(bus_idle),
        .o_clk_en(clk_en0), .o_sleeping(sleeping0), .o_wake_ack(ack0),
        .o_sleep_cycles(cyc0)
    );

    serv_pwr_ctrl #(.WAKE_DLY(4), .CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_sleep_req(sleep_req),
        .i_wakeup_req(wakeup_req), .i_bus_idle(bus_idle),
        .o_clk_en(clk_en4), .o_sleeping(sleeping4), .o_wake_ack(ack4),
        .o_sleep_cycles(cyc4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sleep_req = 1'b0; wakeup_req = 1'b0; bus_idle = 1'b1;
        do_reset();

        // Reset state of all instances
        check("rst_clk_en", 32'(clk_en2), 32'd1);
        check("rst_sleeping", 32'(sleeping2), 32'd0);
        check("rst_ack", 32'(ack2), 32'd0);
        check("rst_cycles", 32'(cyc2), 32'd0);
        check("rst_clk_en_d0", 32'(clk_en0), 32'd1);
        check("rst_clk_en_d4", 32'(clk_en4), 32'd1);

        // Basic sleep / wake with WAKE_DLY=2
        sleep_req = 1'b1; bus_idle = 1'b1;
        step();
        check("drain_clk_en", 32'(clk_en2), 32'd1);
        step();
        check("sleep_clk_en", 32'(clk_en2), 32'd0);
        check("sleep_sleeping", 32'(sleeping2), 32'd1);
        wakeup_req = 1'b1;
        step();
        check("wake1_clk_en", 32'(clk_en2), 32'd0);
        step();
        check("wake2_clk_en", 32'(clk_en2), 32'd0);
        check("wake2_ack", 32'(ack2), 32'd0);
        step();
        check("run_clk_en", 32'(clk_en2), 32'd1);
        check("run_ack", 32'(ack2), 32'd1);
        check("run_sleeping", 32'(sleeping2), 32'd0);
        check("cycles_after_wake", 32'(cyc2), CNT_ON ? 32'd3 : 32'd0);
        sleep_req = 1'b0; wakeup_req = 1'b0;
        step();
        check("ack_one_cycle", 32'(ack2), 32'd0);

        // Bus busy holds DRAIN
        sleep_req = 1'b1; bus_idle = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("drain_hold_%0d", i), 32'(clk_en2), 32'd1);
            check($sformatf("drain_nosleep_%0d", i), 32'(sleeping2), 32'd0);
            step();
        end
        check("drain_hold_5", 32'(clk_en2), 32'd1);
        bus_idle = 1'b1;
        step();
        check("idle_to_sleep", 32'(clk_en2), 32'd0);
        wakeup_req = 1'b1;
        step();
        step();
        step();
        check("busy_wake_ack", 32'(ack2), 32'd1);
        sleep_req = 1'b0; wakeup_req = 1'b0;
        step();

        // WFI with pending wakeup acts as a NOP
        sleep_req = 1'b1; wakeup_req = 1'b1;
        step();
        check("nop_ack", 32'(ack2), 32'd1);
        check("nop_clk_en", 32'(clk_en2), 32'd1);
        check("nop_sleeping", 32'(sleeping2), 32'd0);
        sleep_req = 1'b0; wakeup_req = 1'b0;
        step();
        check("nop_ack_clear", 32'(ack2), 32'd0);
        check("nop_clk_en2", 32'(clk_en2), 32'd1);

        // Wakeup beats bus_idle in DRAIN
        sleep_req = 1'b1; bus_idle = 1'b0;
        step();
        wakeup_req = 1'b1; bus_idle = 1'b1;
        step();
        check("drain_wake_ack", 32'(ack2), 32'd1);
        check("drain_wake_clk_en", 32'(clk_en2), 32'd1);
        sleep_req = 1'b0; wakeup_req = 1'b0;
        step();

        // WAKE_DLY=0 and a 1-cycle wakeup pulse into WAKE_DLY=4
        do_reset();
        sleep_req = 1'b1; bus_idle = 1'b1;
        step();
        step();
        check("d0_sleep_clk_en", 32'(clk_en0), 32'd0);
        check("d4_sleep_clk_en", 32'(clk_en4), 32'd0);
        wakeup_req = 1'b1;
        step();
        check("d0_wake_clk_en", 32'(clk_en0), 32'd1);
        check("d0_wake_ack", 32'(ack0), 32'd1);
        check("d4_wake_started", 32'(sleeping4), 32'd1);
        wakeup_req = 1'b0;
        step();
        step();
        step();
        check("d4_still_gated", 32'(clk_en4), 32'd0);
        step();
        check("d4_wake_clk_en", 32'(clk_en4), 32'd1);
        check("d4_wake_ack", 32'(ack4), 32'd1);
        sleep_req = 1'b0;
        step();

        // Reset during WAKE abandons the wake
        do_reset();
        sleep_req = 1'b1; bus_idle = 1'b1;
        step();
        step();
        wakeup_req = 1'b1;
        step();
        check("in_wake_sleeping", 32'(sleeping2), 32'd1);
        rst = 1'b1;
        step();
        check("wrst_clk_en", 32'(clk_en2), 32'd1);
        check("wrst_sleeping", 32'(sleeping2), 32'd0);
        check("wrst_ack", 32'(ack2), 32'd0);
        check("wrst_cycles", 32'(cyc2), 32'd0);
        rst = 1'b0; sleep_req = 1'b0; wakeup_req = 1'b0;
        step();
        check("wrst_no_ack", 32'(ack2), 32'd0);

        // Counter saturation over a long sleep
        sleep_req = 1'b1; bus_idle = 1'b1;
        step();
        step();
        repeat (20) step();
        check("cycles_saturate", 32'(cyc2), CNT_ON ? 32'hF : 32'd0);
        wakeup_req = 1'b1;
        step();
        step();
        step();
        check("sat_wake_ack", 32'(ack2), 32'd1);
        check("cycles_hold_sat", 32'(cyc2), CNT_ON ? 32'hF : 32'd0);
        sleep_req = 1'b0; wakeup_req = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
